traffic_light_controller: RTL and testbench

Sequences the two-way intersection lights (north-south / east-west) plus a pedestrian walk phase, with a night-time flashing mode. Consumes the one-cycle `tick` pulse from the existing clock divider as its time base and counts ticks per phase. Outputs drive the lamp drivers directly. The divider remains a separate instance feeding `tick`.

---
 rtl/traffic_pkg.sv | 22 ++
 rtl/phase_timer.sv | 41 ++++
 rtl/traffic_light_controller.sv | 129 ++++++++++++
 tb/tb_traffic_light_controller.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/traffic_pkg.sv
// Shared types and lamp encodings for the traffic light controller.
package traffic_pkg;

   // Controller states; the 3-bit encoding is exported on the phase port.
   typedef enum logic [2:0] {
      NS_GREEN  = 3'd0,
      NS_YELLOW = 3'd1,
      ALL_RED_1 = 3'd2,
      EW_GREEN  = 3'd3,
      EW_YELLOW = 3'd4,
      ALL_RED_2 = 3'd5,
      WALK      = 3'd6,
      FLASH     = 3'd7
   } state_t;

   // One-hot {R,Y,G} lamp drive values.
   localparam logic [2:0] LAMP_R   = 3'b100;
   localparam logic [2:0] LAMP_Y   = 3'b010;
   localparam logic [2:0] LAMP_G   = 3'b001;
   localparam logic [2:0] LAMP_OFF = 3'b000;

endpackage

// File: rtl/phase_timer.sv
// Down-counter measuring phase duration in ticks. Loaded with duration-1 on
// state entry; done pulses on the tick that finds the count at zero.
module phase_timer #(
   parameter int               CNT_W   = 8,
   parameter logic [CNT_W-1:0] RST_VAL = '0
) (
   input  logic             sys_clk,
   input  logic             reset_n,
   input  logic             tick,
   input  logic             load,
   input  logic [CNT_W-1:0] load_val,
   output logic             done
);

   logic [CNT_W-1:0] count_q;
   logic [CNT_W-1:0] count_d;

   // Next count: load wins, otherwise decrement on tick, holding at zero.
   always_comb begin
      // NOTE: assign every always_comb output a default first so no path leaves it unassigned (which would infer a latch).
      count_d = count_q;
      if (load) begin
         count_d = load_val;
      end else if (tick && (count_q != '0)) begin
         count_d = count_q - 1'b1;
      end
   end

   // Count register with synchronous active-low reset.
   always_ff @(posedge sys_clk) begin
      // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
      if (!reset_n) begin
         count_q <= RST_VAL;
      end else begin
         count_q <= count_d;
      end
   end

   assign done = (count_q == '0) && tick;

endmodule

// File: rtl/traffic_light_controller.sv
// Two-way intersection controller with pedestrian walk phase and night-time
// flashing. Moore outputs decoded from the state register. On entry to FLASH
// the yellow lamps are lit first, then alternate with off on every tick.
module traffic_light_controller
   import traffic_pkg::*;
#(
   parameter int GREEN_TICKS   = 10,
   parameter int YELLOW_TICKS  = 3,
   parameter int ALL_RED_TICKS = 2,
   parameter int WALK_TICKS    = 8,
   parameter int CNT_W         = 8
) (
   input  logic       sys_clk,
   input  logic       reset_n,
   input  logic       tick,
   input  logic       ped_req,
   input  logic       night_mode,
   output logic [2:0] ns_light,
   output logic [2:0] ew_light,
   output logic       walk,
   output logic [2:0] phase
);

   localparam logic [CNT_W-1:0] GREEN_LD   = CNT_W'(GREEN_TICKS - 1);
   localparam logic [CNT_W-1:0] YELLOW_LD  = CNT_W'(YELLOW_TICKS - 1);
   localparam logic [CNT_W-1:0] ALL_RED_LD = CNT_W'(ALL_RED_TICKS - 1);
   localparam logic [CNT_W-1:0] WALK_LD    = CNT_W'(WALK_TICKS - 1);

   state_t           state_q, state_d;
   logic             ped_pending_q, ped_pending_d;
   logic             flash_on_q, flash_on_d;
   logic             timer_load;
   logic [CNT_W-1:0] timer_load_val;
   logic             timer_done;
   logic             ped_now;
   logic             enter_walk;

   // Counter reload value for the state being entered; FLASH does not time.
   function automatic logic [CNT_W-1:0] load_for(input state_t s);
      case (s)
         NS_GREEN, EW_GREEN:   return GREEN_LD;
         NS_YELLOW, EW_YELLOW: return YELLOW_LD;
         ALL_RED_1, ALL_RED_2: return ALL_RED_LD;
         WALK:                 return WALK_LD;
         default:              return '0;
      endcase
   endfunction

   phase_timer #(
      .CNT_W   (CNT_W),
      .RST_VAL (ALL_RED_LD)
   ) u_phase_timer (
      .sys_clk  (sys_clk),
      .reset_n  (reset_n),
      .tick     (tick),
      .load     (timer_load),
      .load_val (timer_load_val),
      .done     (timer_done)
   );

   // A request sampled this cycle counts in the decision taken on this edge.
   assign ped_now = ped_pending_q | (ped_req & (state_q != WALK));

   // Next-state logic, timer reload, pedestrian latch and flash toggle.
   always_comb begin
      state_d = state_q;
      case (state_q)
         NS_GREEN:  if (timer_done) state_d = NS_YELLOW;
         NS_YELLOW: if (timer_done) state_d = ALL_RED_1;
         ALL_RED_1: if (timer_done) state_d = EW_GREEN;
         EW_GREEN:  if (timer_done) state_d = EW_YELLOW;
         EW_YELLOW: if (timer_done) state_d = ALL_RED_2;
         ALL_RED_2: begin
            if (timer_done) begin
               if (night_mode)   state_d = FLASH;
               else if (ped_now) state_d = WALK;
               else              state_d = NS_GREEN;
            end
         end
         WALK:      if (timer_done) state_d = NS_GREEN;
         FLASH:     if (tick && !night_mode) state_d = ALL_RED_2;
         default:   state_d = ALL_RED_2;
      endcase

      timer_load     = (state_d != state_q);
      timer_load_val = load_for(state_d);

      enter_walk    = (state_d == WALK) && (state_q != WALK);
      ped_pending_d = ped_now & ~enter_walk;

      // Entry into FLASH always happens on a tick, so the lamps start lit.
      flash_on_d = (state_d == FLASH) ? (flash_on_q ^ tick) : 1'b0;
   end

   // Control state registers with synchronous active-low reset.
   always_ff @(posedge sys_clk) begin
      if (!reset_n) begin
         state_q       <= ALL_RED_2;
         ped_pending_q <= 1'b0;
         flash_on_q    <= 1'b0;
      end else begin
         state_q       <= state_d;
         ped_pending_q <= ped_pending_d;
         flash_on_q    <= flash_on_d;
      end
   end

   // Lamp decode from the registered state.
   always_comb begin
      ns_light = LAMP_R;
      ew_light = LAMP_R;
      walk     = 1'b0;
      case (state_q)
         NS_GREEN:  ns_light = LAMP_G;
         NS_YELLOW: ns_light = LAMP_Y;
         EW_GREEN:  ew_light = LAMP_G;
         EW_YELLOW: ew_light = LAMP_Y;
         WALK:      walk     = 1'b1;
         FLASH: begin
            ns_light = flash_on_q ? LAMP_Y : LAMP_OFF;
            ew_light = flash_on_q ? LAMP_Y : LAMP_OFF;
         end
         default: ;
      endcase
   end

   assign phase = state_q;

endmodule

// File: tb/tb_traffic_light_controller.sv
// Scoreboard bench: the driver applies stimulus on the falling edge, steps a
// tick-counting reference model and queues the expected outputs; the monitor
// compares after each rising edge.
module tb_traffic_light_controller;
   import traffic_pkg::*;

   localparam int GREEN   = 4;
   localparam int YELLOW  = 2;
   localparam int ALL_RED = 1;
   localparam int WALKT   = 3;

   typedef struct packed {
      logic [2:0] phase;
      logic [2:0] ns;
      logic [2:0] ew;
      logic       walk;
   } exp_t;

   logic       sys_clk;
   logic       reset_n;
   logic       tick;
   logic       ped_req;
   logic       night_mode;
   logic [2:0] ns_light;
   logic [2:0] ew_light;
   logic       walk;
   logic [2:0] phase;

   exp_t exp_q[$];
   int   vectors;
   int   miscompares;
   bit   stim_done;

   // Reference model: current phase, ticks elapsed in it, pending request, flash lamp.
   state_t m_state;
   int     m_elapsed;
   bit     m_ped;
   bit     m_flash;

   traffic_light_controller #(
      .GREEN_TICKS   (GREEN),
      .YELLOW_TICKS  (YELLOW),
      .ALL_RED_TICKS (ALL_RED),
      .WALK_TICKS    (WALKT),
      .CNT_W         (8)
   ) dut (
      .sys_clk    (sys_clk),
      .reset_n    (reset_n),
      .tick       (tick),
      .ped_req    (ped_req),
      .night_mode (night_mode),
      .ns_light   (ns_light),
      .ew_light   (ew_light),
      .walk       (walk),
      .phase      (phase)
   );

   initial sys_clk = 1'b1;
   always #5 sys_clk = ~sys_clk;

   function automatic int dur(input state_t s);
      case (s)
         NS_GREEN, EW_GREEN:   return GREEN;
         NS_YELLOW, EW_YELLOW: return YELLOW;
         ALL_RED_1, ALL_RED_2: return ALL_RED;
         WALK:                 return WALKT;
         default:              return 0;
      endcase
   endfunction

   function automatic exp_t model_outputs();
      exp_t e;
      e.phase = m_state;
      e.ns    = LAMP_R;
      e.ew    = LAMP_R;
      e.walk  = (m_state == WALK);
      case (m_state)
         NS_GREEN:  e.ns = LAMP_G;
         NS_YELLOW: e.ns = LAMP_Y;
         EW_GREEN:  e.ew = LAMP_G;
         EW_YELLOW: e.ew = LAMP_Y;
         FLASH: begin
            e.ns = m_flash ? LAMP_Y : LAMP_OFF;
            e.ew = e.ns;
         end
         default: ;
      endcase
      return e;
   endfunction

   // Advance the model by one clock edge with the given inputs.
   task automatic model_step(input logic r, input logic t, input logic p, input logic n);
      state_t nxt;
      bit     ped_now;
      if (!r) begin
         m_state = ALL_RED_2; m_elapsed = 0; m_ped = 0; m_flash = 0;
         return;
      end
      ped_now = m_ped || (p && m_state != WALK);
      nxt = m_state;
      if (m_state == FLASH) begin
         if (t) begin
            m_flash = !m_flash;
            if (!n) nxt = ALL_RED_2;
         end
      end else if (t) begin
         m_elapsed++;
         if (m_elapsed == dur(m_state)) begin
            case (m_state)
               NS_GREEN:  nxt = NS_YELLOW;
               NS_YELLOW: nxt = ALL_RED_1;
               ALL_RED_1: nxt = EW_GREEN;
               EW_GREEN:  nxt = EW_YELLOW;
               EW_YELLOW: nxt = ALL_RED_2;
               ALL_RED_2: nxt = n ? FLASH : (ped_now ? WALK : NS_GREEN);
               default:   nxt = NS_GREEN;
            endcase
         end
      end
      m_ped = ped_now && !(nxt == WALK && m_state != WALK);
      if (nxt != m_state) begin
         m_elapsed = 0;
         m_flash   = (nxt == FLASH);
      end
      m_state = nxt;
   endtask

   task automatic drive(input logic r, input logic t, input logic p, input logic n);
      @(negedge sys_clk);
      reset_n    = r;
      tick       = t;
      ped_req    = p;
      night_mode = n;
      model_step(r, t, p, n);
      exp_q.push_back(model_outputs());
   endtask

   // Run with tick held high until the model reaches the target phase.
   task automatic wait_state(input state_t target, input logic n, input string tag);
      for (int i = 0; i < 60; i++) begin
         if (m_state == target) return;
         drive(1'b1, 1'b1, 1'b0, n);
      end
      $display("FAIL wait_%s: phase %0d never reached target %0d", tag, m_state, target);
      miscompares++;
   endtask

   task automatic check(input string name, input logic [2:0] act, input logic [2:0] exp);
      if (act !== exp) begin
         $display("FAIL %s at %0t: got %b expected %b", name, $time, act, exp);
         miscompares++;
      end
   endtask

   // Monitor: compare DUT outputs against the queued expectations.
   initial begin
      exp_t e;
      forever begin
         @(posedge sys_clk);
         #1;
         if (exp_q.size() == 0) begin
            if (!stim_done) begin
               $display("FAIL scoreboard_underflow at %0t: got empty queue expected an entry", $time);
               miscompares++;
            end
         end else begin
            e = exp_q.pop_front();
            vectors++;
            check("phase", phase, e.phase);
            check("ns_light", ns_light, e.ns);
            check("ew_light", ew_light, e.ew);
            check("walk", {2'b00, walk}, {2'b00, e.walk});
            if (phase != FLASH && ns_light != LAMP_R && ew_light != LAMP_R) begin
               $display("FAIL safety at %0t: got ns=%b ew=%b expected one red", $time, ns_light, ew_light);
               miscompares++;
            end
         end
      end
   end

   // Driver: directed scenarios followed by random traffic.
   initial begin
      logic n_lvl;
      vectors = 0; miscompares = 0; stim_done = 0;
      reset_n = 0; tick = 0; ped_req = 0; night_mode = 0;
      m_state = ALL_RED_2; m_elapsed = 0; m_ped = 0; m_flash = 0;

      // Reset with tick active: tick must be ignored.
      for (int i = 0; i < 3; i++) drive(1'b0, 1'b1, 1'b0, 1'b0);
      // Idle sequence.
      for (int i = 0; i < 30; i++) drive(1'b1, 1'b1, 1'b0, 1'b0);

      // One-cycle request during EW_GREEN.
      wait_state(EW_GREEN, 1'b0, "ew_green_a");
      drive(1'b1, 1'b1, 1'b1, 1'b0);
      for (int i = 0; i < 20; i++) drive(1'b1, 1'b1, 1'b0, 1'b0);

      // Request held from ALL_RED_2 throughout WALK, dropped on exit.
      wait_state(EW_YELLOW, 1'b0, "ew_yellow_a");
      for (int i = 0; i < 40 && m_state != WALK; i++) drive(1'b1, 1'b1, 1'b1, 1'b0);
      for (int i = 0; i < 40 && m_state == WALK; i++) drive(1'b1, 1'b1, 1'b1, 1'b0);
      for (int i = 0; i < 20; i++) drive(1'b1, 1'b1, 1'b0, 1'b0);

      // Request only in the final ALL_RED_2 cycle.
      wait_state(ALL_RED_2, 1'b0, "all_red_2");
      drive(1'b1, 1'b1, 1'b1, 1'b0);
      for (int i = 0; i < 10; i++) drive(1'b1, 1'b1, 1'b0, 1'b0);

      // Night mode raised during NS_GREEN, then dropped.
      wait_state(NS_GREEN, 1'b0, "ns_green");
      for (int i = 0; i < 30; i++) drive(1'b1, 1'b1, 1'b0, 1'b1);
      for (int i = 0; i < 10; i++) drive(1'b1, 1'b1, 1'b0, 1'b0);

      // Tick every third cycle, then tick stuck low.
      for (int i = 0; i < 60; i++) drive(1'b1, (i % 3) == 0, 1'b0, 1'b0);
      for (int i = 0; i < 20; i++) drive(1'b1, 1'b0, 1'b0, 1'b0);

      // Reset during EW_YELLOW with a pending request.
      wait_state(EW_GREEN, 1'b0, "ew_green_b");
      drive(1'b1, 1'b1, 1'b1, 1'b0);
      wait_state(EW_YELLOW, 1'b0, "ew_yellow_b");
      drive(1'b0, 1'b1, 1'b0, 1'b0);
      for (int i = 0; i < 15; i++) drive(1'b1, 1'b1, 1'b0, 1'b0);

      // Random traffic.
      n_lvl = 1'b0;
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 49) == 0) n_lvl = ~n_lvl;
         drive($urandom_range(0, 399) != 0,
               $urandom_range(0, 3) != 0,
               $urandom_range(0, 7) == 0,
               n_lvl);
      end

      @(posedge sys_clk);
      #2;
      stim_done = 1;
      if (exp_q.size() != 0) begin
         $display("FAIL drain: got %0d entries left expected 0", exp_q.size());
         miscompares++;
      end
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
